// File: rtl/bram_port_arbiter_pkg.sv
// Shared types and sizes for the data-BRAM port arbiter.
// The BRAM geometry matches the core's single-port byte-write data memory.
package bram_port_arbiter_pkg;

  localparam int unsigned ADDR_WIDTH      = 10;
  localparam int unsigned NB_COL          = 4;
  localparam int unsigned COL_WIDTH       = 8;
  localparam int unsigned DWIDTH          = NB_COL * COL_WIDTH;
  localparam int unsigned ARB_NUM_REQ     = 4;
  localparam int unsigned BRAM_RD_LATENCY = 1;

  typedef struct packed {
    logic [NB_COL-1:0]     we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DWIDTH-1:0]     wdata;
  } bram_cmd_t;

  // A command with no byte lanes enabled is a read.
  function automatic logic cmd_is_read(input bram_cmd_t cmd);
    return (cmd.we == '0);
  endfunction

endpackage

// File: rtl/bram_port_arbiter_rr_grant.sv
// Combinational rotate-priority encoder: the first requester at or after ptr wins.
// Produces a one-hot grant, its binary index and an any-grant flag.
module bram_port_arbiter_rr_grant
  import bram_port_arbiter_pkg::*;
#(
  parameter int unsigned N = ARB_NUM_REQ
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt_c,
  output logic [$clog2(N)-1:0] idx_c,
  output logic                 any_c
);

  localparam int unsigned IDXW = $clog2(N);
  localparam int unsigned PW   = IDXW + 1;

  logic [PW-1:0] pos;
  logic          found;

  // Scan ptr, ptr+1, ... modulo N; ptr < N and k < N keep pos below 2N.
  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = PW'(ptr) + PW'(k);
      if (pos >= PW'(N)) begin
        pos = pos - PW'(N);
      end
      if (!found && req[pos[IDXW-1:0]]) begin
        found                = 1'b1;
        gnt_c[pos[IDXW-1:0]] = 1'b1;
        idx_c                = pos[IDXW-1:0];
      end
    end
    any_c = found;
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one byte-write data-BRAM port among NUM_REQ requesters.
// Commands are registered onto the BRAM port; read responses are routed back by a one-hot tag.
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = ARB_NUM_REQ,
  parameter int unsigned RD_LATENCY = BRAM_RD_LATENCY
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ-1:0][NB_COL-1:0]      req_we,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ-1:0][DWIDTH-1:0]      req_wdata,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  output logic [DWIDTH-1:0]                   rsp_rdata,
  output logic                                bram_en,
  output logic [NB_COL-1:0]                   bram_we,
  output logic [ADDR_WIDTH-1:0]               bram_addr,
  output logic [DWIDTH-1:0]                   bram_wdata,
  input  logic [DWIDTH-1:0]                   bram_rdata
);

  localparam int unsigned IDXW = $clog2(NUM_REQ);

  logic [IDXW-1:0]    ptr_q, ptr_d;
  logic               en_q, en_d;
  bram_cmd_t          cmd_q, cmd_d;
  bram_cmd_t          sel_cmd_c;
  logic [NUM_REQ-1:0] gnt_c;
  logic [IDXW-1:0]    gnt_idx_c;
  logic               gnt_any_c;
  logic               hs_c;

  // Stage 0 lines up with bram_en; the last stage lines up with bram_rdata.
  logic [RD_LATENCY:0][NUM_REQ-1:0] tag_q, tag_d;
  logic [NUM_REQ-1:0]               tag_in_c;

  bram_port_arbiter_rr_grant #(
    .N (NUM_REQ)
  ) u_rr_grant (
    .req   (req_valid),
    .ptr   (ptr_q),
    .gnt_c (gnt_c),
    .idx_c (gnt_idx_c),
    .any_c (gnt_any_c)
  );

  assign req_ready = gnt_c & {NUM_REQ{reset_n}};
  assign hs_c      = gnt_any_c & reset_n;

  always_comb begin
    sel_cmd_c.we    = req_we[gnt_idx_c];
    sel_cmd_c.addr  = req_addr[gnt_idx_c];
    sel_cmd_c.wdata = req_wdata[gnt_idx_c];
  end

  // Next-state: pointer advance, command capture and tag push.
  always_comb begin
    ptr_d    = ptr_q;
    en_d     = 1'b0;
    cmd_d    = cmd_q;
    cmd_d.we = '0;
    tag_in_c = '0;
    if (hs_c) begin
      ptr_d = (gnt_idx_c == IDXW'(NUM_REQ - 1)) ? '0 : gnt_idx_c + IDXW'(1);
      en_d  = 1'b1;
      cmd_d = sel_cmd_c;
      if (cmd_is_read(sel_cmd_c)) begin
        tag_in_c = gnt_c;
      end
    end
    tag_d = {tag_q[RD_LATENCY-1:0], tag_in_c};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
      en_q  <= 1'b0;
      cmd_q <= '0;
      tag_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      en_q  <= en_d;
      cmd_q <= cmd_d;
      tag_q <= tag_d;
    end
  end

  assign bram_en    = en_q;
  assign bram_we    = cmd_q.we;
  assign bram_addr  = cmd_q.addr;
  assign bram_wdata = cmd_q.wdata;
  assign rsp_valid  = tag_q[RD_LATENCY];
  assign rsp_rdata  = bram_rdata;

  a_ready_onehot0 : assert property (@(posedge clk) disable iff (!reset_n) $onehot0(req_ready));
  a_rsp_onehot0   : assert property (@(posedge clk) disable iff (!reset_n) $onehot0(rsp_valid));

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: two instances (read latency 1 and 2) share stimulus,
// each backed by a behavioural BRAM, checked against a cycle-level reference model.
module tb_bram_port_arbiter;
  import bram_port_arbiter_pkg::*;

  localparam int NR = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                               reset_n;
  logic [NR-1:0]                      req_valid;
  logic [NR-1:0][NB_COL-1:0]          req_we;
  logic [NR-1:0][ADDR_WIDTH-1:0]      req_addr;
  logic [NR-1:0][DWIDTH-1:0]          req_wdata;
  logic [NR-1:0]                      rdy_a, rdy_b, rsp_v_a, rsp_v_b;
  logic [DWIDTH-1:0]                  rsp_d_a, rsp_d_b, rd_a, rd_b;
  logic                               en_a, en_b;
  logic [NB_COL-1:0]                  we_a, we_b;
  logic [ADDR_WIDTH-1:0]              addr_a, addr_b;
  logic [DWIDTH-1:0]                  wd_a, wd_b;

  bram_port_arbiter #(.NUM_REQ(NR), .RD_LATENCY(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(rdy_a),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_v_a), .rsp_rdata(rsp_d_a), .bram_en(en_a), .bram_we(we_a),
    .bram_addr(addr_a), .bram_wdata(wd_a), .bram_rdata(rd_a)
  );

  bram_port_arbiter #(.NUM_REQ(NR), .RD_LATENCY(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(rdy_b),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_v_b), .rsp_rdata(rsp_d_b), .bram_en(en_b), .bram_we(we_b),
    .bram_addr(addr_b), .bram_wdata(wd_b), .bram_rdata(rd_b)
  );

  // Behavioural BRAMs
  logic [DWIDTH-1:0] mem_a [0:1023];
  logic [DWIDTH-1:0] mem_b [0:1023];
  logic [DWIDTH-1:0] ra1, rb1, rb2;

  always @(posedge clk) begin
    if (en_a) begin
      for (int c = 0; c < NB_COL; c++)
        if (we_a[c]) mem_a[addr_a][c*8 +: 8] <= wd_a[c*8 +: 8];
      ra1 <= mem_a[addr_a];
    end
  end
  always @(posedge clk) begin
    if (en_b) begin
      for (int c = 0; c < NB_COL; c++)
        if (we_b[c]) mem_b[addr_b][c*8 +: 8] <= wd_b[c*8 +: 8];
      rb1 <= mem_b[addr_b];
    end
    rb2 <= rb1;
  end
  assign rd_a = ra1;
  assign rd_b = rb2;

  // Reference model state
  typedef struct { int due; logic [NR-1:0] tag; logic [DWIDTH-1:0] data; } rsp_t;
  rsp_t q_a[$];
  rsp_t q_b[$];
  logic [DWIDTH-1:0] ref_mem [0:1023];
  int ptr_m, cyc;
  logic                  exp_en;
  logic [NB_COL-1:0]     exp_we;
  logic [ADDR_WIDTH-1:0] exp_addr;
  logic [DWIDTH-1:0]     exp_wd;

  // Staged stimulus, applied by step() at the falling edge
  logic                          rst_in;
  logic [NR-1:0]                 v_in;
  logic [NR-1:0][NB_COL-1:0]     we_in;
  logic [NR-1:0][ADDR_WIDTH-1:0] addr_in;
  logic [NR-1:0][DWIDTH-1:0]     wd_in;

  int n_tests, n_fail;
  logic [NR-1:0]     last_t_a;
  logic [DWIDTH-1:0] last_d_a;
  logic              any_rsp;
  int                rsp_cyc_b [NR];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(output logic [NR-1:0] gnt);
    logic [NR-1:0] eg;
    int g;
    @(negedge clk);
    cyc++;
    chk("bram_en_a", 64'(en_a), 64'(exp_en));
    chk("bram_en_b", 64'(en_b), 64'(exp_en));
    chk("bram_we_a", 64'(we_a), 64'(exp_we));
    chk("bram_we_b", 64'(we_b), 64'(exp_we));
    chk("bram_addr_a", 64'(addr_a), 64'(exp_addr));
    chk("bram_addr_b", 64'(addr_b), 64'(exp_addr));
    chk("bram_wdata_a", 64'(wd_a), 64'(exp_wd));
    chk("bram_wdata_b", 64'(wd_b), 64'(exp_wd));
    if (q_a.size() > 0 && q_a[0].due == cyc) begin
      chk("rsp_valid_a", 64'(rsp_v_a), 64'(q_a[0].tag));
      chk("rsp_rdata_a", 64'(rsp_d_a), 64'(q_a[0].data));
      void'(q_a.pop_front());
    end else chk("rsp_valid_a", 64'(rsp_v_a), 64'(0));
    if (q_b.size() > 0 && q_b[0].due == cyc) begin
      chk("rsp_valid_b", 64'(rsp_v_b), 64'(q_b[0].tag));
      chk("rsp_rdata_b", 64'(rsp_d_b), 64'(q_b[0].data));
      void'(q_b.pop_front());
    end else chk("rsp_valid_b", 64'(rsp_v_b), 64'(0));
    if (rsp_v_a != '0) begin
      last_t_a = rsp_v_a;
      last_d_a = rsp_d_a;
      any_rsp  = 1'b1;
    end
    if (rsp_v_b != '0) any_rsp = 1'b1;
    for (int i = 0; i < NR; i++) if (rsp_v_b[i]) rsp_cyc_b[i] = cyc;

    reset_n   = rst_in;
    req_valid = v_in;
    req_we    = we_in;
    req_addr  = addr_in;
    req_wdata = wd_in;
    #1;
    eg = '0;
    if (!rst_in) begin
      ptr_m = 0;
      q_a.delete();
      q_b.delete();
      exp_en = 1'b0; exp_we = '0; exp_addr = '0; exp_wd = '0;
    end else begin
      g = -1;
      for (int k = 0; k < NR; k++)
        if (g < 0 && v_in[(ptr_m + k) % NR]) g = (ptr_m + k) % NR;
      exp_en = 1'b0;
      exp_we = '0;
      if (g >= 0) begin
        eg[g]    = 1'b1;
        ptr_m    = (g + 1) % NR;
        exp_en   = 1'b1;
        exp_we   = we_in[g];
        exp_addr = addr_in[g];
        exp_wd   = wd_in[g];
        if (we_in[g] == '0) begin
          q_a.push_back('{cyc + 2, eg, ref_mem[addr_in[g]]});
          q_b.push_back('{cyc + 3, eg, ref_mem[addr_in[g]]});
        end else begin
          for (int c = 0; c < NB_COL; c++)
            if (we_in[g][c]) ref_mem[addr_in[g]][c*8 +: 8] = wd_in[g][c*8 +: 8];
        end
      end
    end
    chk("req_ready_a", 64'(rdy_a), 64'(eg));
    chk("req_ready_b", 64'(rdy_b), 64'(eg));
    gnt = eg;
  endtask

  typedef struct { logic [NR-1:0] valid; logic [NR-1:0] ready; } vec_t;
  vec_t tbl [15];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NR-1:0] g;
    logic [NR-1:0] pend;
    int n0;

    tbl[0]  = '{4'b1111, 4'b0001};
    tbl[1]  = '{4'b1111, 4'b0010};
    tbl[2]  = '{4'b1111, 4'b0100};
    tbl[3]  = '{4'b1111, 4'b1000};
    tbl[4]  = '{4'b0111, 4'b0001};
    tbl[5]  = '{4'b0110, 4'b0010};
    tbl[6]  = '{4'b0100, 4'b0100};
    tbl[7]  = '{4'b0100, 4'b0100};
    tbl[8]  = '{4'b0100, 4'b0100};
    tbl[9]  = '{4'b0000, 4'b0000};
    tbl[10] = '{4'b0011, 4'b0001};
    tbl[11] = '{4'b1010, 4'b0010};
    tbl[12] = '{4'b1000, 4'b1000};
    tbl[13] = '{4'b1001, 4'b0001};
    tbl[14] = '{4'b1000, 4'b1000};

    n_tests = 0; n_fail = 0; cyc = 0; ptr_m = 0;
    exp_en = 1'b0; exp_we = '0; exp_addr = '0; exp_wd = '0;
    last_t_a = '0; last_d_a = '0; any_rsp = 1'b0;
    for (int i = 0; i < NR; i++) rsp_cyc_b[i] = -1;
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i] = (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
      mem_a[i]   = ref_mem[i];
      mem_b[i]   = ref_mem[i];
    end
    reset_n = 1'b0; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    rst_in = 1'b0; v_in = '0; we_in = '0; addr_in = '0; wd_in = '0;

    // Reset, then idle
    repeat (3) step(g);
    rst_in = 1'b1;
    repeat (11) step(g);

    // Grant rotation table: reads of 0x10..0x13
    for (int i = 0; i < NR; i++) addr_in[i] = ADDR_WIDTH'(16 + i);
    for (int i = 0; i < 15; i++) begin
      v_in = tbl[i].valid;
      step(g);
      chk($sformatf("tbl%0d_ready_a", i), 64'(rdy_a), 64'(tbl[i].ready));
      chk($sformatf("tbl%0d_ready_b", i), 64'(rdy_b), 64'(tbl[i].ready));
    end
    v_in = '0;
    repeat (4) step(g);

    // Requester 2: full write then read back
    last_t_a = '0; last_d_a = '0;
    v_in = 4'b0100; we_in[2] = 4'b1111; addr_in[2] = 10'h005; wd_in[2] = 32'hDEAD_BEEF;
    step(g);
    we_in[2] = 4'b0000;
    step(g);
    v_in = '0;
    repeat (3) step(g);
    chk("wr_rd_tag", 64'(last_t_a), 64'(4'b0100));
    chk("wr_rd_data", 64'(last_d_a), 64'(32'hDEAD_BEEF));

    // Partial byte-lane write then read back
    last_t_a = '0; last_d_a = '0;
    v_in = 4'b0100; we_in[2] = 4'b0010; wd_in[2] = 32'h0000_AB00;
    step(g);
    we_in[2] = 4'b0000;
    step(g);
    v_in = '0;
    repeat (3) step(g);
    chk("partial_data", 64'(last_d_a), 64'(32'hDEAD_ABEF));

    // Back-to-back reads from 1 then 3; instance b has read latency 2
    for (int i = 0; i < NR; i++) rsp_cyc_b[i] = -1;
    we_in = '0; addr_in[1] = 10'h020; addr_in[3] = 10'h021;
    v_in = 4'b0010;
    step(g);
    n0 = cyc;
    v_in = 4'b1000;
    step(g);
    v_in = '0;
    repeat (4) step(g);
    chk("lat2_rsp_req1_cycle", 64'(rsp_cyc_b[1]), 64'(n0 + 3));
    chk("lat2_rsp_req3_cycle", 64'(rsp_cyc_b[3]), 64'(n0 + 4));

    // Reset one cycle after a read handshake: response must be dropped
    addr_in[0] = 10'h030;
    v_in = 4'b0001;
    step(g);
    any_rsp = 1'b0;
    rst_in = 1'b0; v_in = '0;
    repeat (5) step(g);
    chk("rst_drop_rsp", 64'(any_rsp), 64'(0));
    rst_in = 1'b1; v_in = 4'b1111;
    step(g);
    chk("post_rst_grant_a", 64'(rdy_a), 64'(4'b0001));
    chk("post_rst_grant_b", 64'(rdy_b), 64'(4'b0001));
    v_in = 4'b1110; step(g);
    v_in = 4'b1100; step(g);
    v_in = 4'b1000; step(g);
    v_in = '0;
    repeat (4) step(g);

    // Random traffic; a request holds its payload until granted
    pend = '0;
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < 55) begin
          pend[i]    = 1'b1;
          we_in[i]   = ($urandom_range(0, 1) == 0) ? '0 : NB_COL'($urandom);
          addr_in[i] = ADDR_WIDTH'($urandom_range(0, 15));
          wd_in[i]   = $urandom;
        end
      end
      v_in = pend;
      step(g);
      pend = pend & ~g;
    end
    v_in = '0;
    repeat (5) step(g);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
